score_display_ctrl: RTL and testbench



---
 rtl/score_display_ctrl_if.sv | 21 ++
 rtl/score_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_score_display_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/score_display_ctrl_if.sv
// Score display bus between the game FSM (master) and the score display
// sequencer (slave).
interface score_display_ctrl_if;
    logic       score_load;
    logic [5:0] score_in;
    logic       game_over;
    logic       clear;
    logic [5:0] num;
    logic       blank;
    logic       busy;

    modport master (
        output score_load, score_in, game_over, clear,
        input  num, blank, busy
    );

    modport slave (
        input  score_load, score_in, game_over, clear,
        output num, blank, busy
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Score display sequencer: count-up animation, saturation and game-over blink.
// Define COUNT_DOWN_EN to animate downward score changes instead of snapping.
module score_display_ctrl #(
    parameter int TICK_DIV    = 5000000,
    parameter int BLINK_TICKS = 5,
    parameter int MAX_VAL     = 19
) (
    input logic               clk,
    input logic               reset,
    score_display_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [5:0]    MAX6     = 6'(MAX_VAL);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        BLINK
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    num_q, num_d;
    logic [5:0]    target_q, target_d;
    logic          blank_q, blank_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          tick;
    logic [5:0]    load_val;

    assign tick     = (presc_q == PRE_LAST);
    assign load_val = (bus.score_in > MAX6) ? MAX6 : bus.score_in;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        target_d = target_q;
        blank_d  = blank_q;
        blink_d  = blink_q;
        presc_d  = tick ? '0 : presc_q + 1'b1;

        if (bus.clear) begin
            state_d  = IDLE;
            num_d    = '0;
            target_d = '0;
            blank_d  = 1'b0;
            blink_d  = '0;
            presc_d  = '0;
        end else if (bus.game_over && state_q != BLINK) begin
            // A same-cycle load lands in target before the freeze.
            target_d = bus.score_load ? load_val : target_q;
            num_d    = target_d;
            state_d  = BLINK;
            blank_d  = 1'b0;
            blink_d  = '0;
            presc_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.score_load) begin
                        target_d = load_val;
                        if (load_val > num_q) begin
                            state_d = COUNT;
                            presc_d = '0;
`ifdef COUNT_DOWN_EN
                        end else if (load_val < num_q) begin
                            state_d = COUNT;
                            presc_d = '0;
`else
                        end else begin
                            num_d = load_val;
`endif
                        end
                    end
                end
                COUNT: begin
                    if (bus.score_load) begin
                        target_d = load_val;
`ifdef COUNT_DOWN_EN
                        if (load_val == num_q) begin
                            state_d = IDLE;
                        end
`else
                        if (load_val <= num_q) begin
                            num_d   = load_val;
                            state_d = IDLE;
                        end
`endif
                    end else if (tick) begin
                        if (num_q < target_q) begin
                            num_d = num_q + 6'd1;
`ifdef COUNT_DOWN_EN
                        end else if (num_q > target_q) begin
                            num_d = num_q - 6'd1;
`endif
                        end
                        if (num_d == target_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                BLINK: begin
                    if (tick) begin
                        if (blink_q == BLK_LAST) begin
                            blink_d = '0;
                            blank_d = ~blank_q;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            num_q    <= '0;
            target_q <= '0;
            blank_q  <= 1'b0;
            blink_q  <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            target_q <= target_d;
            blank_q  <= blank_d;
            blink_q  <= blink_d;
            presc_q  <= presc_d;
        end
    end

    assign bus.num   = num_q;
    assign bus.blank = blank_q;
    assign bus.busy  = (state_q == COUNT);
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with TICK_DIV=4, BLINK_TICKS=2.
// Build with +define+COUNT_DOWN_EN to check the count-down variant.
module tb_score_display_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    score_display_ctrl_if bus_if ();

    score_display_ctrl #(
        .TICK_DIV   (4),
        .BLINK_TICKS(2),
        .MAX_VAL    (19)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] v);
        bus_if.score_load = 1'b1;
        bus_if.score_in   = v;
        step(1);
        bus_if.score_load = 1'b0;
    endtask

    task automatic do_clear();
        bus_if.clear = 1'b1;
        step(1);
        bus_if.clear = 1'b0;
    endtask

    initial begin
        bus_if.score_load = 1'b0;
        bus_if.score_in   = '0;
        bus_if.game_over  = 1'b0;
        bus_if.clear      = 1'b0;

        // 1: reset, then count 0 -> 5
        step(2);
        reset = 1'b0;
        chk("rst_num", bus_if.num, 0);
        chk("rst_blank", bus_if.blank, 0);
        chk("rst_busy", bus_if.busy, 0);
        load(6'd5);
        chk("t1_busy", bus_if.busy, 1);
        step(3);
        chk("t1_hold0", bus_if.num, 0);
        step(1);
        chk("t1_n1", bus_if.num, 1);
        for (int k = 2; k <= 5; k++) begin
            step(4);
            chk($sformatf("t1_n%0d", k), bus_if.num, k);
            chk($sformatf("t1_busy%0d", k), bus_if.busy, k < 5 ? 1 : 0);
        end

        // 2: saturation at 19
        do_clear();
        chk("t2_clr", bus_if.num, 0);
        load(6'd25);
        chk("t2_busy", bus_if.busy, 1);
        step(72);
        chk("t2_n18", bus_if.num, 18);
        step(4);
        chk("t2_n19", bus_if.num, 19);
        chk("t2_done", bus_if.busy, 0);
        step(8);
        chk("t2_stay", bus_if.num, 19);

        // 3: downward change from 7 to 3
        do_clear();
        load(6'd7);
        step(28);
        chk("t3_n7", bus_if.num, 7);
        chk("t3_idle", bus_if.busy, 0);
        load(6'd3);
`ifdef COUNT_DOWN_EN
        chk("t3_busy", bus_if.busy, 1);
        chk("t3_hold", bus_if.num, 7);
        step(3);
        for (int k = 6; k >= 3; k--) begin
            step(1);
            chk($sformatf("t3_dn%0d", k), bus_if.num, k);
            chk($sformatf("t3_bz%0d", k), bus_if.busy, k > 3 ? 1 : 0);
            if (k > 3) step(3);
        end
`else
        chk("t3_snap", bus_if.num, 3);
        chk("t3_busy", bus_if.busy, 0);
`endif
        load(6'd3);
        chk("t3_eq", bus_if.num, 3);
        chk("t3_eqbz", bus_if.busy, 0);

        // mid-count retarget keeps the prescaler phase
        do_clear();
        load(6'd9);
        step(5);
        load(6'd12);
        step(2);
        chk("rt_n2", bus_if.num, 2);
        chk("rt_busy", bus_if.busy, 1);

        // 4: game over during 0 -> 9
        do_clear();
        load(6'd9);
        step(16);
        chk("t4_n4", bus_if.num, 4);
        bus_if.game_over = 1'b1;
        step(1);
        chk("t4_n9", bus_if.num, 9);
        chk("t4_bl0", bus_if.blank, 0);
        chk("t4_busy", bus_if.busy, 0);
        step(7);
        chk("t4_bl0b", bus_if.blank, 0);
        bus_if.game_over = 1'b0;
        step(1);
        chk("t4_bl1", bus_if.blank, 1);
        step(8);
        chk("t4_bl2", bus_if.blank, 0);
        load(6'd2);
        chk("t4_ign", bus_if.num, 9);
        do_clear();
        chk("t4_cn", bus_if.num, 0);
        chk("t4_cb", bus_if.blank, 0);
        chk("t4_cbz", bus_if.busy, 0);

        // game_over with a same-cycle oversize load
        bus_if.game_over = 1'b1;
        load(6'd25);
        bus_if.game_over = 1'b0;
        chk("go_ld", bus_if.num, 19);
        do_clear();

        // 5: clear beats load
        bus_if.clear = 1'b1;
        load(6'd6);
        bus_if.clear = 1'b0;
        chk("t5_num", bus_if.num, 0);
        chk("t5_busy", bus_if.busy, 0);
        step(8);
        chk("t5_num2", bus_if.num, 0);

        // 6: reset mid-count
        load(6'd9);
        step(12);
        chk("t6_n3", bus_if.num, 3);
        reset = 1'b1;
        step(1);
        chk("t6_num", bus_if.num, 0);
        chk("t6_blank", bus_if.blank, 0);
        chk("t6_busy", bus_if.busy, 0);
        reset = 1'b0;
        step(8);
        chk("t6_stay", bus_if.num, 0);
        chk("t6_idle", bus_if.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
